// File: rtl/id_ex_stage_buf.sv
// id_ex_stage_buf: ID/EX pipeline stage with valid/ready, two-entry skid buffer, flush and writeback bypass
module id_ex_stage_buf #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 3,
  parameter int CTRL_W  = 4,
  parameter int X0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              regwrite_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data1_in,
  input  logic [DATA_W-1:0] data2_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [REG_AW-1:0] rs1_in,
  input  logic [REG_AW-1:0] rs2_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              regwrite_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data1_out,
  output logic [DATA_W-1:0] data2_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [REG_AW-1:0] rs1_out,
  output logic [REG_AW-1:0] rs2_out
);
  typedef struct packed {
    logic              v;
    logic              rw;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } ent_t;
  ent_t m, s, m_n, s_n, in_e;
  logic accept, drain;
  function automatic logic match(input logic [REG_AW-1:0] x);
    return wb_en && (wb_rd == x) && !((X0_ZERO != 0) && (x == '0));
  endfunction
  function automatic ent_t byp(input ent_t e);
    ent_t r;
    r = e;
    r.d1 = (e.v && match(e.rs1)) ? wb_data : e.d1;
    r.d2 = (e.v && match(e.rs2)) ? wb_data : e.d2;
    return r;
  endfunction
  always_comb begin
    accept = in_valid & in_ready;
    drain = m.v & out_ready;
    in_e.v = 1'b1;
    in_e.rw = regwrite_in;
    in_e.ctrl = ctrl_in;
    in_e.d1 = match(rs1_in) ? wb_data : data1_in;
    in_e.d2 = match(rs2_in) ? wb_data : data2_in;
    in_e.rd = rd_in;
    in_e.rs1 = rs1_in;
    in_e.rs2 = rs2_in;
    m_n = m;
    s_n = s;
    if (flush) begin
      m_n = '0;
      s_n = '0;
    end else if (!m.v || drain) begin
      // in_ready is low whenever SKID is full, so SKID->MAIN never races an accept
      m_n = s.v ? byp(s) : (accept ? in_e : '0);
      s_n = '0;
    end else begin
      m_n = byp(m);
      s_n = accept ? in_e : byp(s);
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      m <= '0;
      s <= '0;
    end else begin
      m <= m_n;
      s <= s_n;
    end
  assign in_ready = ~s.v;
  assign out_valid = m.v;
  assign regwrite_out = m.rw;
  assign ctrl_out = m.ctrl;
  assign data1_out = m.d1;
  assign data2_out = m.d2;
  assign rd_out = m.rd;
  assign rs1_out = m.rs1;
  assign rs2_out = m.rs2;
endmodule

// File: tb/tb_id_ex_stage_buf.sv
// tb_id_ex_stage_buf: directed self-checking bench for id_ex_stage_buf
module tb_id_ex_stage_buf;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, regwrite_in = 0, flush = 0, wb_en = 0, out_valid, out_ready = 0, regwrite_out;
  logic [3:0] ctrl_in = 0, ctrl_out;
  logic [7:0] data1_in = 0, data2_in = 0, wb_data = 0, data1_out, data2_out;
  logic [2:0] rd_in = 0, rs1_in = 0, rs2_in = 0, wb_rd = 0, rd_out, rs1_out, rs2_out;
  int n_chk = 0, n_fail = 0;
  id_ex_stage_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .regwrite_in(regwrite_in),
    .ctrl_in(ctrl_in), .data1_in(data1_in), .data2_in(data2_in), .rd_in(rd_in), .rs1_in(rs1_in),
    .rs2_in(rs2_in), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .regwrite_out(regwrite_out), .ctrl_out(ctrl_out),
    .data1_out(data1_out), .data2_out(data2_out), .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic v, input logic rw, input logic [3:0] c, input logic [7:0] a,
                     input logic [7:0] b, input logic [2:0] d, input logic [2:0] r1, input logic [2:0] r2);
    in_valid = v; regwrite_in = rw; ctrl_in = c; data1_in = a; data2_in = b;
    rd_in = d; rs1_in = r1; rs2_in = r2;
  endtask
  task automatic test_reset;
    #2;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    n_chk++; if ({regwrite_out, ctrl_out, data1_out, data2_out, rd_out, rs1_out, rs2_out} !== '0) begin
      n_fail++; $display("FAIL reset_fields got %h %h %h %h exp 0", ctrl_out, data1_out, data2_out, rd_out); end
    @(negedge clk);
    rst = 1;
    step;
  endtask
  task automatic test_stream;
    logic [7:0] e;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      e = 8'((i + 1) * 17);
      put(1, 1, 4'(i), e, 8'h00, 3'd1, 3'd2, 3'd3);
      step;
      n_chk++; if (out_valid !== 1'b1 || data1_out !== e) begin
        n_fail++; $display("FAIL stream_%0d got v=%b d1=%h exp v=1 d1=%h", i, out_valid, data1_out, e); end
      n_chk++; if (in_ready !== 1'b1 || ctrl_out !== 4'(i)) begin
        n_fail++; $display("FAIL stream_rdy_%0d got rdy=%b ctrl=%h exp rdy=1 ctrl=%h", i, in_ready, ctrl_out, 4'(i)); end
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    n_chk++; if (out_valid !== 1'b0 || regwrite_out !== 1'b0) begin
      n_fail++; $display("FAIL stream_end got v=%b rw=%b exp 0 0", out_valid, regwrite_out); end
  endtask
  task automatic test_stall_skid;
    out_ready = 0;
    put(1, 1, 4'h1, 8'hA1, 8'h00, 3'd1, 3'd2, 3'd3);
    step;
    n_chk++; if (data1_out !== 8'hA1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_a got d1=%h rdy=%b exp A1 1", data1_out, in_ready); end
    put(1, 1, 4'h2, 8'hB2, 8'h00, 3'd1, 3'd2, 3'd3);
    step;
    n_chk++; if (data1_out !== 8'hA1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_b got d1=%h rdy=%b exp A1 0", data1_out, in_ready); end
    put(1, 1, 4'h3, 8'hC3, 8'h00, 3'd1, 3'd2, 3'd3);
    step;
    n_chk++; if (data1_out !== 8'hA1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_c_held got d1=%h rdy=%b v=%b exp A1 0 1", data1_out, in_ready, out_valid); end
    out_ready = 1;
    step;
    n_chk++; if (data1_out !== 8'hB2 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_b got d1=%h rdy=%b exp B2 1", data1_out, in_ready); end
    step;
    n_chk++; if (data1_out !== 8'hC3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL release_c got d1=%h v=%b exp C3 1", data1_out, out_valid); end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_empty got v=%b exp 0", out_valid); end
  endtask
  task automatic test_bypass_capture;
    out_ready = 1;
    put(1, 0, 0, 8'h05, 8'h00, 3'd1, 3'd3, 3'd2);
    wb_en = 1; wb_rd = 3; wb_data = 8'hA7;
    step;
    n_chk++; if (data1_out !== 8'hA7 || data2_out !== 8'h00) begin
      n_fail++; $display("FAIL cap_r3 got d1=%h d2=%h exp A7 00", data1_out, data2_out); end
    put(1, 0, 0, 8'h05, 8'h00, 3'd1, 3'd0, 3'd2);
    wb_rd = 0;
    step;
    n_chk++; if (data1_out !== 8'h05) begin n_fail++; $display("FAIL cap_x0 got d1=%h exp 05", data1_out); end
    put(1, 0, 0, 8'h01, 8'h02, 3'd1, 3'd4, 3'd4);
    wb_rd = 4; wb_data = 8'h99;
    step;
    n_chk++; if (data1_out !== 8'h99 || data2_out !== 8'h99) begin
      n_fail++; $display("FAIL cap_same got d1=%h d2=%h exp 99 99", data1_out, data2_out); end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    wb_en = 0;
    step;
  endtask
  task automatic test_bypass_stall;
    out_ready = 0;
    put(1, 1, 4'h5, 8'h01, 8'h10, 3'd2, 3'd1, 3'd5);
    step;
    n_chk++; if (data2_out !== 8'h10) begin n_fail++; $display("FAIL hold_a got d2=%h exp 10", data2_out); end
    put(1, 1, 4'h6, 8'h06, 8'h07, 3'd2, 3'd6, 3'd7);
    step;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_skid got rdy=%b exp 0", in_ready); end
    step;
    wb_en = 1; wb_rd = 5; wb_data = 8'h3C;
    step;
    n_chk++; if (data2_out !== 8'h3C || out_valid !== 1'b1 || data1_out !== 8'h01) begin
      n_fail++; $display("FAIL hold_wb got d2=%h v=%b d1=%h exp 3C 1 01", data2_out, out_valid, data1_out); end
    wb_rd = 6; wb_data = 8'h66;
    step;
    wb_rd = 7; wb_data = 8'h77; out_ready = 1;
    step;
    wb_en = 0;
    n_chk++; if (data1_out !== 8'h66 || data2_out !== 8'h77 || in_ready !== 1'b1 || ctrl_out !== 4'h6) begin
      n_fail++; $display("FAIL skid_wb got d1=%h d2=%h rdy=%b ctrl=%h exp 66 77 1 6", data1_out, data2_out, in_ready, ctrl_out); end
    step;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_wb_empty got v=%b exp 0", out_valid); end
  endtask
  task automatic test_flush;
    out_ready = 0;
    put(1, 1, 4'h1, 8'hE1, 8'h00, 3'd1, 3'd2, 3'd3);
    step;
    put(1, 1, 4'h2, 8'hE2, 8'h00, 3'd1, 3'd2, 3'd3);
    step;
    put(1, 1, 4'h3, 8'hE3, 8'h00, 3'd1, 3'd2, 3'd3);
    flush = 1;
    step;
    flush = 0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (out_valid !== 1'b0 || regwrite_out !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush got v=%b rw=%b rdy=%b exp 0 0 1", out_valid, regwrite_out, in_ready); end
    out_ready = 1;
    step;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_gone got v=%b exp 0", out_valid); end
  endtask
  task automatic test_async_reset;
    out_ready = 0;
    put(1, 1, 4'h1, 8'hF1, 8'h00, 3'd1, 3'd2, 3'd3);
    step;
    put(1, 1, 4'h2, 8'hF2, 8'h00, 3'd1, 3'd2, 3'd3);
    step;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 0;
    #1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || data1_out !== 8'h00 || regwrite_out !== 1'b0) begin
      n_fail++; $display("FAIL areset got v=%b rdy=%b d1=%h rw=%b exp 0 1 00 0", out_valid, in_ready, data1_out, regwrite_out); end
    @(negedge clk);
    rst = 1;
    out_ready = 1;
    step;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_stale got v=%b exp 0", out_valid); end
    put(1, 0, 4'h9, 8'h5D, 8'h00, 3'd1, 3'd2, 3'd3);
    step;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (out_valid !== 1'b1 || data1_out !== 8'h5D) begin
      n_fail++; $display("FAIL areset_first got v=%b d1=%h exp 1 5D", out_valid, data1_out); end
  endtask
  initial begin
    test_reset;
    test_stream;
    test_stall_skid;
    test_bypass_capture;
    test_bypass_stall;
    test_flush;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
